// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and a counter-width helper.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      FIX  = 2'd3
   } state_t;

   localparam int unsigned W_DEF = 8;

   // Bits needed to count 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_i [w:0]   partial remainder before the step
//   bit_i         next dividend bit shifted into the remainder
//   d_i   [w-1:0] divisor magnitude
//   rem_c [w:0]   partial remainder after the step
//   q_c           quotient bit produced by this step
module div_step
   import seq_div_pkg::*;
#(
   parameter int unsigned w = W_DEF
) (
   input  logic [w:0]   rem_i,
   input  logic         bit_i,
   input  logic [w-1:0] d_i,
   output logic [w:0]   rem_c,
   output logic         q_c
);

   logic [w:0]   shifted_c;
   logic [w+1:0] diff_c;

   // Shift in the next bit, trial-subtract; the extra MSB flags a negative result.
   always_comb begin
      shifted_c = {rem_i[w-1:0], bit_i};
      diff_c    = {1'b0, shifted_c} - {2'b00, d_i};
      q_c       = ~diff_c[w+1];
      rem_c     = q_c ? diff_c[w:0] : shifted_c;
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: 2w-bit dividend / w-bit divisor, one restoring
// step per clock, C-style truncation (remainder takes the dividend's sign).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, x, y     request and operands, accepted only while busy=0
//   q, r            signed quotient / remainder, held until the next done
//   busy, done      handshake: busy while working, done pulses for one cycle
//   div0, ovf       result flags, updated together with done
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned w = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*w-1:0] x,
   input  logic [w-1:0]   y,
   output logic [w-1:0]   q,
   output logic [w-1:0]   r,
   output logic           busy,
   output logic           done,
   output logic           div0,
   output logic           ovf
);

   localparam int unsigned W2 = 2 * w;
   localparam int unsigned CW = clog2(w);
   localparam logic [w-1:0] QPOS_MAX = {1'b0, {(w-1){1'b1}}};
   localparam logic [w-1:0] QNEG_MAX = {1'b1, {(w-1){1'b0}}};

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]  x_q, x_d;
   logic [w-1:0]   y_q, y_d;
   logic [w-1:0]   ay_q, ay_d;
   logic [w:0]     rem_q, rem_d;
   logic [w-1:0]   quo_q, quo_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           err_div0_q, err_div0_d;
   logic           err_ovf_q, err_ovf_d;
   logic [w-1:0]   qout_q, qout_d;
   logic [w-1:0]   rout_q, rout_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           div0_q, div0_d;
   logic           ovf_q, ovf_d;

   logic [W2-1:0]  ax_c;
   logic [w-1:0]   ay_c;
   logic [w:0]     step_rem_c;
   logic           step_bit_c;
   logic           post_ovf_c;

   div_step #(.w(w)) u_step (
      .rem_i (rem_q),
      .bit_i (quo_q[w-1]),
      .d_i   (ay_q),
      .rem_c (step_rem_c),
      .q_c   (step_bit_c)
   );

   // Operand magnitudes; the most negative values map to 2^(n-1) unsigned.
   always_comb begin
      ax_c       = x_q[W2-1] ? (~x_q + W2'(1)) : x_q;
      ay_c       = y_q[w-1]  ? (~y_q + w'(1))  : y_q;
      post_ovf_c = qneg_q ? (quo_q > QNEG_MAX) : (quo_q > QPOS_MAX);
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      ay_d       = ay_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      err_div0_d = err_div0_q;
      err_ovf_d  = err_ovf_q;
      qout_d     = qout_q;
      rout_d     = rout_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div0_d     = div0_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = x;
               y_d     = y;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            qneg_d     = x_q[W2-1] ^ y_q[w-1];
            rneg_d     = x_q[W2-1];
            ay_d       = ay_c;
            err_div0_d = 1'b0;
            err_ovf_d  = 1'b0;
            if (y_q == '0) begin
               err_div0_d = 1'b1;
               state_d    = FIX;
            end else if (ax_c[W2-1:w] >= ay_c) begin
               // Quotient would need more than w bits: skip the iterations.
               err_ovf_d = 1'b1;
               state_d   = FIX;
            end else begin
               rem_d   = {1'b0, ax_c[W2-1:w]};
               quo_d   = ax_c[w-1:0];
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            rem_d = step_rem_c;
            quo_d = {quo_q[w-2:0], step_bit_c};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(w - 1)) state_d = FIX;
         end
         FIX: begin
            if (err_div0_q) begin
               div0_d = 1'b1;
               ovf_d  = 1'b0;
               qout_d = '0;
               rout_d = '0;
            end else if (err_ovf_q || post_ovf_c) begin
               div0_d = 1'b0;
               ovf_d  = 1'b1;
               qout_d = '0;
               rout_d = '0;
            end else begin
               div0_d = 1'b0;
               ovf_d  = 1'b0;
               qout_d = qneg_q ? (~quo_q + w'(1)) : quo_q;
               rout_d = rneg_q ? (~rem_q[w-1:0] + w'(1)) : rem_q[w-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         ay_q       <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         err_div0_q <= 1'b0;
         err_ovf_q  <= 1'b0;
         qout_q     <= '0;
         rout_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         ay_q       <= ay_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         err_div0_q <= err_div0_d;
         err_ovf_q  <= err_ovf_d;
         qout_q     <= qout_d;
         rout_q     <= rout_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div0_q     <= div0_d;
         ovf_q      <= ovf_d;
      end
   end

   assign q    = qout_q;
   assign r    = rout_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (w=8): the driver queues expected results
// with the cycle their done must appear; a monitor pops on every done.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] x;
   logic [7:0]  y;
   logic [7:0]  q, r;
   logic        busy, done, div0, ovf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string      name;
      logic [7:0] q;
      logic [7:0] r;
      logic       div0;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   seq_divider #(.w(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", n, got, exp);
      end
   endtask

   // Monitor: every done must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_q"},    int'(q),    int'(e.q));
            chk({e.name, "_r"},    int'(r),    int'(e.r));
            chk({e.name, "_div0"}, int'(div0), int'(e.div0));
            chk({e.name, "_ovf"},  int'(ovf),  int'(e.ovf));
            chk({e.name, "_cyc"},  cyc,        e.due);
            chk({e.name, "_busy"}, int'(busy), 0);
         end
      end
   end

   // Drive a request at the current negedge and queue its expected result.
   task automatic drive(input string n, input logic [15:0] xi, input logic [7:0] yi,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ed, input logic eo, input int lat);
      exp_t t;
      start  = 1'b1;
      x      = xi;
      y      = yi;
      t.name = n;
      t.q    = eq;
      t.r    = er;
      t.div0 = ed;
      t.ovf  = eo;
      t.due  = cyc + 1 + lat;
      sb.push_back(t);
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 40; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending results required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic op(input string n, input logic [15:0] xi, input logic [7:0] yi,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic ed, input logic eo, input int lat);
      drive(n, xi, yi, eq, er, ed, eo, lat);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_q"},    int'(q),    0);
      chk({n, "_r"},    int'(r),    0);
      chk({n, "_busy"}, int'(busy), 0);
      chk({n, "_done"}, int'(done), 0);
      chk({n, "_div0"}, int'(div0), 0);
      chk({n, "_ovf"},  int'(ovf),  0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic divide with busy observed over the whole operation.
      drive("pos_pos", 16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 10);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk("busy_hi", int'(busy), 1);
      end
      wait_idle();
      @(negedge clk);

      op("neg_pos",  16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10);
      op("pos_neg",  16'd100,  8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10);
      op("neg_neg",  16'hFF9C, 8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 10);
      op("min_q",    16'hFF00, 8'd2,   8'h80, 8'h00, 1'b0, 1'b0, 10);
      op("post_ovf", 16'h0100, 8'd2,   8'h00, 8'h00, 1'b0, 1'b1, 10);
      op("pre_ovf",  16'h8000, 8'h80,  8'h00, 8'h00, 1'b0, 1'b1, 2);
      op("div0",     16'd50,   8'd0,   8'h00, 8'h00, 1'b1, 1'b0, 2);

      // Extra start pulses while busy must be ignored.
      drive("ignore", 16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 10);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; x = 16'd5; y = 8'd1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);

      // start held high: second request accepted on the edge ending done.
      drive("held1", 16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 10);
      repeat (11) @(negedge clk);
      drive("held2", 16'hFF9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 10);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      // Reset mid-operation discards the work and issues no done.
      start = 1'b1; x = 16'd1000; y = 8'd9;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      repeat (15) @(negedge clk);
      op("after_rst", 16'd1000, 8'd9, 8'd111, 8'd1, 1'b0, 1'b0, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
